// File: rtl/demux7_collector.sv
// Serial-to-parallel 1-to-7 collector: steers accepted bits into slots 0..6, then offers the word on a valid/ready port.
// Optional trailing even-parity bit enabled by defining DEMUX7_PARITY_EN.
module demux7_collector #(
    parameter int unsigned SLOTS = 7,
    parameter int unsigned SELW  = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In,
    input  logic             InValid,
    output logic             InReady,
    output logic [SELW-1:0]  Select,
    output logic [SLOTS-1:0] Word,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             ParityErr
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
`ifdef DEMUX7_PARITY_EN
        PARITY  = 2'd1,
`endif
        FULL    = 2'd2
    } state_t;

    state_t state;
    logic   accept;
    logic   last_slot;

    // FULL passes downstream readiness straight through so a retiring word costs no bubble
    assign InReady   = (state == FULL) ? OutReady : 1'b1;
    assign accept    = InValid & InReady;
    assign last_slot = (Select == SELW'(SLOTS - 1));

`ifndef DEMUX7_PARITY_EN
    assign ParityErr = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= COLLECT;
            Select   <= '0;
            Word     <= '0;
            OutValid <= 1'b0;
`ifdef DEMUX7_PARITY_EN
            ParityErr <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        Word[Select] <= In;
                        if (last_slot) begin
                            Select <= '0;
`ifdef DEMUX7_PARITY_EN
                            state  <= PARITY;
`else
                            state    <= FULL;
                            OutValid <= 1'b1;
`endif
                        end else begin
                            Select <= Select + SELW'(1);
                        end
                    end
                end
`ifdef DEMUX7_PARITY_EN
                // Parity bit is checked against the stored data, never written into Word
                PARITY: begin
                    if (accept) begin
                        ParityErr <= ^{Word, In};
                        OutValid  <= 1'b1;
                        state     <= FULL;
                    end
                end
`endif
                FULL: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        state    <= COLLECT;
`ifdef DEMUX7_PARITY_EN
                        ParityErr <= 1'b0;
`endif
                        // A bit arriving with the retiring handshake opens the next word
                        if (InValid) begin
                            Word[0] <= In;
                            Select  <= SELW'(1);
                        end
                    end
                end
                default: begin
                    state    <= COLLECT;
                    Select   <= '0;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux7_collector.sv
// Scoreboard bench for demux7_collector: driver queues expected words, a negedge monitor checks each handshake.
module tb_demux7_collector;

`ifdef DEMUX7_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 8 : 7;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       In = 1'b0;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [2:0] Select;
    logic [6:0] Word;
    logic       OutValid;
    logic       OutReady = 1'b0;
    logic       ParityErr;

    typedef struct packed {
        logic [6:0] word;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    demux7_collector dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .In       (In),
        .InValid  (InValid),
        .InReady  (InReady),
        .Select   (Select),
        .Word     (Word),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ParityErr(ParityErr)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        InValid = 1'b1;
        In      = b;
        cyc();
    endtask

    task automatic push_exp(input logic [6:0] d, input logic p);
        exp_t e;
        e.word = d;
        e.perr = PAR ? ^{d, p} : 1'b0;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [6:0] d, input logic p);
        push_exp(d, p);
        for (int i = 0; i < 7; i++) send_bit(d[i]);
        if (PAR) send_bit(p);
        InValid = 1'b0;
    endtask

    // Monitor: a handshake seen at negedge completes on the following posedge
    always @(negedge Clock) begin
        if (!Reset && OutValid && OutReady) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 32'(Word), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word", 32'(Word), 32'(e.word));
                chk("parity_err", 32'(ParityErr), 32'(e.perr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] bits;
        int acc;

        // Reset held for two cycles
        cyc();
        cyc();
        chk("rst_select", 32'(Select), 0);
        chk("rst_word", 32'(Word), 0);
        chk("rst_outvalid", 32'(OutValid), 0);
        chk("rst_inready", 32'(InReady), 1);
        chk("rst_parity", 32'(ParityErr), 0);
        Reset = 1'b0;

        // Seven consecutive bits with downstream always ready
        OutReady = 1'b1;
        bits = 7'b1001101;
        push_exp(bits, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk("t2_select_step", 32'(Select), 32'(i));
            send_bit(bits[i]);
        end
        if (PAR) send_bit(1'b0);
        InValid = 1'b0;
        chk("t2_outvalid_rise", 32'(OutValid), 1);
        chk("t2_select_wrap", 32'(Select), 0);
        chk("t2_word", 32'(Word), 32'(7'b1001101));
        cyc();
        chk("t2_outvalid_fall", 32'(OutValid), 0);

        // Downstream stalls: incoming bits must be held off
        OutReady = 1'b0;
        send_word(7'b0110010, 1'b1);
        chk("t3_outvalid", 32'(OutValid), 1);
        InValid = 1'b1;
        In      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_inready_stall", 32'(InReady), 0);
            cyc();
            chk("t3_word_held", 32'(Word), 32'(7'b0110010));
        end
        chk("t3_select_held", 32'(Select), 0);
        push_exp(7'b0000001, 1'b1);
        OutReady = 1'b1;
        In       = 1'b1;
        cyc();
        chk("t3_outvalid_fall", 32'(OutValid), 0);
        chk("t3_select_one", 32'(Select), 1);
        chk("t3_slot0", 32'(Word[0]), 1);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        if (PAR) send_bit(1'b1);
        InValid = 1'b0;
        chk("t3_second_valid", 32'(OutValid), 1);
        cyc();

        // Alternating valid: idle cycles must not advance Select
        acc = 0;
        for (int i = 0; i < 2 * NB; i++) begin
            InValid = (i % 2 == 0);
            In      = 1'b1;
            if (InValid && acc == 0) push_exp(7'h7F, 1'b1);
            cyc();
            if (i % 2 == 0) acc++;
            chk("t4_select", 32'(Select), 32'((acc >= 7) ? 0 : acc));
            chk("t4_outvalid", 32'(OutValid), 32'(i == 2 * (NB - 1)));
        end
        InValid = 1'b0;

        // Reset mid-word discards the partial word, reset beats a valid bit
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("t5_select_pre", 32'(Select), 4);
        Reset   = 1'b1;
        InValid = 1'b1;
        In      = 1'b1;
        cyc();
        Reset   = 1'b0;
        InValid = 1'b0;
        chk("t5_select_rst", 32'(Select), 0);
        chk("t5_outvalid_rst", 32'(OutValid), 0);
        chk("t5_word_rst", 32'(Word), 0);
        send_word(7'b0101010, 1'b1);
        chk("t5_outvalid", 32'(OutValid), 1);
        cyc();

        if (PAR) begin
            // Good parity, then a corrupted parity bit on the same data
            OutReady = 1'b0;
            push_exp(7'b0000011, 1'b0);
            for (int i = 0; i < 7; i++) send_bit((i < 2) ? 1'b1 : 1'b0);
            chk("t6_select_parity", 32'(Select), 0);
            chk("t6_no_valid_before_parity", 32'(OutValid), 0);
            send_bit(1'b0);
            InValid = 1'b0;
            chk("t6_valid_good", 32'(OutValid), 1);
            chk("t6_perr_good", 32'(ParityErr), 0);
            OutReady = 1'b1;
            cyc();
            OutReady = 1'b0;
            push_exp(7'b0000011, 1'b1);
            for (int i = 0; i < 7; i++) send_bit((i < 2) ? 1'b1 : 1'b0);
            send_bit(1'b1);
            InValid = 1'b0;
            chk("t6_perr_bad", 32'(ParityErr), 1);
            OutReady = 1'b1;
            cyc();
            chk("t6_perr_cleared", 32'(ParityErr), 0);
        end

        repeat (3) cyc();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
